// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared state type and size helpers for the runtime-loadable LUT neuron
package lut_neuron_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int calc_addr_w(input int fan_in, input int in_w);
    return fan_in * in_w;
  endfunction
  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/lut_neuron_ram.sv
// lut_neuron_ram: truth-table storage, one sync write port and one read-before-write sync read port
module lut_neuron_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // table array has no reset so it maps onto distributed RAM; the sweep in the top initialises it
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read samples the pre-write contents when both ports hit the same entry
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/lut_neuron_rt.sv
// lut_neuron_rt: pipelined LUT neuron whose truth table is cleared after reset and loaded at run time
module lut_neuron_rt
  import lut_neuron_pkg::*;
#(
  parameter int FAN_IN = 4,
  parameter int IN_W = 2,
  parameter int OUT_W = 2,
  parameter logic [OUT_W-1:0] CLEAR_VAL = '0,
  localparam int ADDR_W = calc_addr_w(FAN_IN, IN_W),
  localparam int DEPTH = calc_depth(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [OUT_W-1:0]  cfg_data,
  output logic              cfg_ready,
  output logic              busy
);
  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_valid;
  logic              s2_valid;
  logic              run;
  logic              adv;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [OUT_W-1:0]  ram_wdata;
  assign run       = state == ST_RUN;
  assign adv       = !s2_valid || out_ready;
  assign in_ready  = run && adv;
  assign accept    = in_valid && in_ready;
  assign cfg_ready = run;
  assign busy      = !run;
  assign out_valid = s2_valid;
  // write port belongs to the clear sweep until RUN, then to the config port
  always_comb begin
    ram_we    = run ? cfg_we : 1'b1;
    ram_waddr = run ? cfg_addr : clr_ptr;
    ram_wdata = run ? cfg_data : CLEAR_VAL;
  end
  // clear sweep walks every entry once, leaving for RUN on the last one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (!run) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (&clr_ptr) state <= ST_RUN;
    end
  // both stages move together; a full S2 facing a stalled consumer freezes the pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) s1_addr <= in_data;
    end
  lut_neuron_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(OUT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (adv && s1_valid),
    .raddr(s1_addr),
    .rdata(out_data)
  );
endmodule

// File: tb/tb_lut_neuron_rt.sv
// tb_lut_neuron_rt: directed vector bench for the runtime-loadable LUT neuron
module tb_lut_neuron_rt;
  typedef struct {
    logic [7:0] addr;
    logic [1:0] exp;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic       cfg_ready;
  logic       busy;
  vec_t       vt [256];
  int         n_cmp = 0;
  int         n_bad = 0;
  lut_neuron_rt dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // pulse reset, check reset values, then count the clear sweep, optionally poking cfg_we into it
  task automatic reset_sweep(input bit poke);
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset values", {in_ready, out_valid, out_data, cfg_ready, busy}, 6'b000001);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 256; c++) begin
      cfg_we   = poke && (c == 0 || c == 100 || c == 101 || c == 255);
      cfg_addr = 8'h10;
      cfg_data = 2'b10;
      #3 check("clear state", {busy, in_ready, cfg_ready, out_valid}, 4'b1000);
      tick();
    end
    cfg_we = 1'b0;
    check("sweep done", {busy, cfg_ready, in_ready}, 3'b011);
  endtask
  task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask
  // push n vectors from vt through the neuron with an optional out_ready stall window
  task automatic stream(input int n, input int stall_at, input int stall_len);
    int sent = 0, got = 0, cyc = 0, first_acc = -1, first_out = -1;
    logic [1:0] held = '0;
    while (got < n && cyc < 2000) begin
      in_valid  = sent < n;
      in_data   = vt[sent < n ? sent : 0].addr;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #3;
      if (!out_ready) begin
        if (cyc == stall_at) held = out_data;
        check("stall hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, held});
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        check("stream data", out_data, vt[got].exp);
        got++;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream count", got, n);
    check("stream latency", first_out - first_acc, 2);
    check("stream cycles", cyc, n + 2 + stall_len);
  endtask
  task automatic load_zero_vecs();
    for (int i = 0; i < 256; i++) vt[i] = '{addr: 8'(i), exp: 2'b00};
  endtask
  initial begin
    logic [7:0] a;
    // reset, sweep length, cfg writes dropped during the sweep, all entries cleared
    reset_sweep(1'b1);
    load_zero_vecs();
    stream(256, -1, 0);
    // identity-low-bits table streamed in ascending order at full rate
    for (int i = 0; i < 256; i++) cfg_write(8'(i), 2'(i));
    for (int i = 0; i < 256; i++) vt[i] = '{addr: 8'(i), exp: 2'(i)};
    stream(256, -1, 0);
    // descending order with a five-cycle consumer stall mid-stream
    for (int i = 0; i < 256; i++) begin
      a = 8'(255 - i);
      vt[i] = '{addr: a, exp: a[1:0]};
    end
    stream(256, 40, 5);
    // same-cycle write to the entry S1 is reading returns the old entry, next read the new one
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    cfg_we   = 1'b1;
    cfg_addr = 8'hA5;
    cfg_data = 2'b11;
    #3 check("collision idle", out_valid, 1'b0);
    tick();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    #3 check("collision old", {out_valid, out_data}, 3'b101);
    tick();
    #3 check("collision new", {out_valid, out_data}, 3'b111);
    tick();
    #3 check("bubble hold", {out_valid, out_data}, 3'b011);
    tick();
    // reset with two beats in flight and a loaded table
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h07;
    tick();
    in_data = 8'h0B;
    tick();
    in_valid = 1'b0;
    #3 check("in flight", {out_valid, in_ready, out_data}, 4'b1011);
    #1 rst = 1'b1;
    #1 check("async drop", {out_valid, busy}, 2'b01);
    tick();
    reset_sweep(1'b0);
    load_zero_vecs();
    stream(256, -1, 0);
    #3 check("no stale beat", out_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
